// File: rtl/apb_pkg.sv
// Shared APB slave definitions: FSM state encoding and wait-counter width.
package apb_pkg;

    // Wide enough for the largest supported wait-state count (15).
    localparam int CNT_W = 4;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_ACCESS = 1'b1
    } state_t;

endpackage

// File: rtl/apb_reg_bank_if.sv
// APB bus bundle between an interconnect (master) and a slave.
interface apb_reg_bank_if #(
    parameter int AWIDTH = 4,
    parameter int DWIDTH = 8
);
    logic              PSEL;
    logic              PENABLE;
    logic              PWRITE;
    logic [AWIDTH-1:0] PADDR;
    logic [DWIDTH-1:0] PWDATA;
    logic [DWIDTH-1:0] PRDATA;
    logic              PREADY;
    logic              PSLVERR;

    modport master (
        output PSEL, PENABLE, PWRITE, PADDR, PWDATA,
        input  PRDATA, PREADY, PSLVERR
    );

    modport slave (
        input  PSEL, PENABLE, PWRITE, PADDR, PWDATA,
        output PRDATA, PREADY, PSLVERR
    );
endinterface

// File: rtl/apb_wait_ctrl.sv
// APB access-phase controller: tracks SETUP/ACCESS and inserts WAIT_STATES
// PREADY-low cycles before a transfer may complete. Shared by APB slaves.
module apb_wait_ctrl
    import apb_pkg::*;
#(
    parameter int WAIT_STATES = 0
) (
    input  logic PCLK,
    input  logic PRESET,
    input  logic PSEL,
    input  logic PENABLE,
    output logic PREADY,
    output logic complete
);

    localparam logic [CNT_W-1:0] WS_INIT = CNT_W'(WAIT_STATES);

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;

    // State register and wait counter; reset abandons any transfer in flight.
    always_ff @(posedge PCLK) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples the pre-edge values regardless of statement order.
        if (PRESET) begin
            state <= ST_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Next-state logic and completion strobe, decoded from registered state.
    always_comb begin
        // NOTE: every output is given a default first so no path through the
        // case statement leaves one unassigned and infers a latch.
        state_nxt = state;
        cnt_nxt   = cnt;
        PREADY    = 1'b0;
        complete  = 1'b0;
        case (state)
            ST_IDLE: begin
                // PENABLE without a preceding SETUP is ignored here.
                if (PSEL && !PENABLE) begin
                    state_nxt = ST_ACCESS;
                    cnt_nxt   = WS_INIT;
                end
            end
            ST_ACCESS: begin
                if (!PSEL) begin
                    // Master abandoned the transfer: nothing completes.
                    state_nxt = ST_IDLE;
                    cnt_nxt   = '0;
                end else if (cnt != '0) begin
                    cnt_nxt = cnt - 1'b1;
                end else if (PENABLE) begin
                    PREADY    = 1'b1;
                    complete  = 1'b1;
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

endmodule

// File: rtl/apb_reg_bank.sv
// APB register bank: NREGS registers of DWIDTH bits, each read/write or
// read-only (RO reads return the matching reg_in slice). Errors on
// out-of-range addresses and writes to RO registers; one-cycle write pulses.
module apb_reg_bank
    import apb_pkg::*;
#(
    parameter int               DWIDTH      = 8,
    parameter int               NREGS       = 4,
    parameter int               AWIDTH      = 4,
    parameter int               WAIT_STATES = 0,
    parameter logic [NREGS-1:0] RO_MASK     = '0
) (
    input  logic                    PCLK,
    input  logic                    PRESET,
    apb_reg_bank_if.slave           apb,
    output logic [NREGS*DWIDTH-1:0] reg_out,
    input  logic [NREGS*DWIDTH-1:0] reg_in,
    output logic [NREGS-1:0]        wr_pulse
);

    logic              complete;
    logic              ro_sel;
    logic              err;
    logic [NREGS-1:0]  hit;
    logic [NREGS-1:0]  we;
    logic [DWIDTH-1:0] rd_data;
    logic [DWIDTH-1:0] regs [NREGS];

    apb_wait_ctrl #(
        .WAIT_STATES(WAIT_STATES)
    ) u_wait_ctrl (
        .PCLK    (PCLK),
        .PRESET  (PRESET),
        .PSEL    (apb.PSEL),
        .PENABLE (apb.PENABLE),
        .PREADY  (apb.PREADY),
        .complete(complete)
    );

    // Address decode and read mux; an address matching no register leaves hit=0.
    always_comb begin
        hit     = '0;
        ro_sel  = 1'b0;
        rd_data = '0;
        for (int i = 0; i < NREGS; i++) begin
            if (apb.PADDR == AWIDTH'(i)) begin
                hit[i]  = 1'b1;
                ro_sel  = RO_MASK[i];
                rd_data = RO_MASK[i] ? reg_in[i*DWIDTH +: DWIDTH] : regs[i];
            end
        end
    end

    assign err         = !(|hit) || (apb.PWRITE && ro_sel);
    assign apb.PSLVERR = apb.PREADY && err;
    assign apb.PRDATA  = (apb.PREADY && !apb.PWRITE && !err) ? rd_data : '0;
    assign we          = hit & {NREGS{complete && apb.PWRITE && !err}};

    // Register array commit and write pulses at the completing edge.
    always_ff @(posedge PCLK) begin
        // NOTE: the register array is reset explicitly because software and
        // downstream control logic rely on known-zero contents after reset.
        if (PRESET) begin
            for (int i = 0; i < NREGS; i++) regs[i] <= '0;
            wr_pulse <= '0;
        end else begin
            for (int i = 0; i < NREGS; i++) begin
                if (we[i]) regs[i] <= apb.PWDATA;
            end
            wr_pulse <= we;
        end
    end

    // Expose RW contents; RO slices carry no storage and read as zero here.
    always_comb begin
        reg_out = '0;
        for (int i = 0; i < NREGS; i++) begin
            reg_out[i*DWIDTH +: DWIDTH] = RO_MASK[i] ? '0 : regs[i];
        end
    end

endmodule

// File: tb/tb_apb_reg_bank.sv
// Bench for apb_reg_bank: a zero-wait instance and a three-wait instance,
// both with register 3 read-only, checked against a register-array model.
module tb_apb_reg_bank;

    localparam logic [3:0] RO = 4'b1000;

    logic        PCLK = 1'b0;
    logic        PRESET;
    logic        psel, penable, pwrite;
    logic [3:0]  paddr;
    logic [7:0]  pwdata;
    logic        sel;       // 0 = zero-wait instance, 1 = three-wait instance
    logic [31:0] reg_in;
    logic [31:0] reg_out0, reg_out1;
    logic [3:0]  wr_pulse0, wr_pulse1;

    int checks = 0;
    int errors = 0;

    logic [7:0] model [2][4];

    always #5 PCLK = ~PCLK;

    apb_reg_bank_if #(.AWIDTH(4), .DWIDTH(8)) bus0 ();
    apb_reg_bank_if #(.AWIDTH(4), .DWIDTH(8)) bus1 ();

    assign bus0.PSEL    = psel & ~sel;
    assign bus1.PSEL    = psel & sel;
    assign bus0.PENABLE = penable;
    assign bus1.PENABLE = penable;
    assign bus0.PWRITE  = pwrite;
    assign bus1.PWRITE  = pwrite;
    assign bus0.PADDR   = paddr;
    assign bus1.PADDR   = paddr;
    assign bus0.PWDATA  = pwdata;
    assign bus1.PWDATA  = pwdata;

    apb_reg_bank #(
        .DWIDTH(8), .NREGS(4), .AWIDTH(4), .WAIT_STATES(0), .RO_MASK(RO)
    ) dut0 (
        .PCLK(PCLK), .PRESET(PRESET), .apb(bus0),
        .reg_out(reg_out0), .reg_in(reg_in), .wr_pulse(wr_pulse0)
    );

    apb_reg_bank #(
        .DWIDTH(8), .NREGS(4), .AWIDTH(4), .WAIT_STATES(3), .RO_MASK(RO)
    ) dut1 (
        .PCLK(PCLK), .PRESET(PRESET), .apb(bus1),
        .reg_out(reg_out1), .reg_in(reg_in), .wr_pulse(wr_pulse1)
    );

    wire        obs_ready  = sel ? bus1.PREADY  : bus0.PREADY;
    wire        obs_slverr = sel ? bus1.PSLVERR : bus0.PSLVERR;
    wire [7:0]  obs_prdata = sel ? bus1.PRDATA  : bus0.PRDATA;
    wire [3:0]  obs_pulse  = sel ? wr_pulse1    : wr_pulse0;
    wire [31:0] obs_regs   = sel ? reg_out1     : reg_out0;

    // ---------------- reference model ----------------
    function automatic logic exp_err(input bit wr, input int addr);
        if (addr >= 4) return 1'b1;
        return wr && RO[addr];
    endfunction

    function automatic logic [7:0] exp_read(input int addr);
        if (addr >= 4) return 8'h00;
        if (RO[addr]) return reg_in[addr*8 +: 8];
        return model[sel][addr];
    endfunction

    function automatic logic [31:0] exp_reg_out(input int d);
        logic [31:0] v;
        v = '0;
        for (int i = 0; i < 4; i++) v[i*8 +: 8] = RO[i] ? 8'h00 : model[d][i];
        return v;
    endfunction

    task automatic clear_model();
        for (int d = 0; d < 2; d++)
            for (int i = 0; i < 4; i++) model[d][i] = 8'h00;
    endtask

    // ---------------- bus driver ----------------
    // Entered at negedge+1; leaves at negedge+1 of the cycle after completion
    // with the bus released, so a following call is a back-to-back SETUP.
    task automatic xfer(input bit wr, input int addr, input logic [7:0] wd,
                        output logic [7:0] rd, output logic err, output int waits);
        bit done;
        psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = addr[3:0]; pwdata = wd;
        #1;
        checks++;
        if (obs_ready !== 1'b0 || obs_prdata !== 8'h00) begin
            errors++;
            $display("FAIL setup_phase: ready=%b prdata=%h, required ready=0 prdata=00", obs_ready, obs_prdata);
        end
        @(negedge PCLK); #1;
        penable = 1'b1;
        #1;
        checks++;
        if (obs_pulse !== 4'b0000) begin
            errors++;
            $display("FAIL pulse_width: wr_pulse=%b in access phase, required 0000", obs_pulse);
        end
        waits = 0; done = 1'b0; rd = 'x; err = 'x;
        while (!done && waits < 40) begin
            if (obs_ready === 1'b1) begin
                rd = obs_prdata; err = obs_slverr; done = 1'b1;
            end else begin
                checks++;
                if (obs_prdata !== 8'h00 || obs_slverr !== 1'b0) begin
                    errors++;
                    $display("FAIL wait_outputs: prdata=%h slverr=%b while not ready, required 00/0", obs_prdata, obs_slverr);
                end
                waits++;
                @(negedge PCLK); #2;
            end
        end
        if (!done) begin
            checks++; errors++;
            $display("FAIL ready_timeout: PREADY not seen after %0d cycles", waits);
        end
        @(negedge PCLK); #1;
        psel = 1'b0; penable = 1'b0;
    endtask

    task automatic xfer_chk(input bit wr, input int addr, input logic [7:0] wd, input string tag);
        logic [7:0] rd, e_rd;
        logic       err, e_err;
        logic [3:0] e_pulse;
        int         waits, e_waits;
        e_err   = exp_err(wr, addr);
        e_rd    = (wr || e_err) ? 8'h00 : exp_read(addr);
        e_waits = sel ? 3 : 0;
        e_pulse = 4'b0000;
        if (wr && !e_err) begin
            model[sel][addr] = wd;
            e_pulse[addr]    = 1'b1;
        end
        xfer(wr, addr, wd, rd, err, waits);
        checks++;
        if (err !== e_err) begin
            errors++;
            $display("FAIL %s pslverr: got %b expected %b (wr=%0d addr=%0d)", tag, err, e_err, wr, addr);
        end
        checks++;
        if (rd !== e_rd) begin
            errors++;
            $display("FAIL %s prdata: got %h expected %h (wr=%0d addr=%0d)", tag, rd, e_rd, wr, addr);
        end
        checks++;
        if (waits != e_waits) begin
            errors++;
            $display("FAIL %s wait_cycles: got %0d expected %0d", tag, waits, e_waits);
        end
        checks++;
        if (obs_pulse !== e_pulse) begin
            errors++;
            $display("FAIL %s wr_pulse: got %b expected %b", tag, obs_pulse, e_pulse);
        end
        checks++;
        if (obs_regs !== exp_reg_out(sel)) begin
            errors++;
            $display("FAIL %s reg_out: got %h expected %h", tag, obs_regs, exp_reg_out(sel));
        end
    endtask

    task automatic check_idle_state(input string tag);
        checks++;
        if (reg_out0 !== exp_reg_out(0) || reg_out1 !== exp_reg_out(1)) begin
            errors++;
            $display("FAIL %s reg_out: got %h/%h expected %h/%h", tag, reg_out0, reg_out1,
                     exp_reg_out(0), exp_reg_out(1));
        end
        checks++;
        if (wr_pulse0 !== 4'b0000 || wr_pulse1 !== 4'b0000 || bus0.PREADY !== 1'b0 || bus1.PREADY !== 1'b0) begin
            errors++;
            $display("FAIL %s quiet: pulse=%b/%b ready=%b/%b, required all 0", tag,
                     wr_pulse0, wr_pulse1, bus0.PREADY, bus1.PREADY);
        end
    endtask

    task automatic apply_reset();
        @(negedge PCLK); #1;
        PRESET = 1'b1;
        repeat (2) @(negedge PCLK);
        #1;
        psel = 1'b0; penable = 1'b0;
        clear_model();
        check_idle_state("reset_held");
        PRESET = 1'b0;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        apply_reset();
        check_idle_state("reset");
        sel = 1'b0;
        for (int a = 0; a < 4; a++) xfer_chk(1'b0, a, 8'h00, "reset_read");
    endtask

    task automatic test_zero_wait();
        sel = 1'b0;
        xfer_chk(1'b1, 2, 8'hA5, "zw_write");
        xfer_chk(1'b0, 2, 8'h00, "zw_read");
    endtask

    task automatic test_wait_states();
        sel = 1'b1;
        xfer_chk(1'b1, 1, 8'h6B, "ws_write");
        xfer_chk(1'b0, 1, 8'h00, "ws_read");
    endtask

    task automatic test_read_only();
        sel = 1'b0;
        xfer_chk(1'b0, 3, 8'h00, "ro_read");
        xfer_chk(1'b1, 3, 8'hFF, "ro_write");
        xfer_chk(1'b0, 3, 8'h00, "ro_reread");
        xfer_chk(1'b1, 5, 8'h42, "oor_write");
        xfer_chk(1'b0, 5, 8'h00, "oor_read");
        xfer_chk(1'b0, 15, 8'h00, "oor_top");
    endtask

    task automatic test_reset_abort();
        sel = 1'b1;
        @(negedge PCLK); #1;
        psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 4'd0; pwdata = 8'h11;
        @(negedge PCLK); #1;
        penable = 1'b1;
        @(negedge PCLK); #1;
        apply_reset();
        repeat (4) begin
            @(negedge PCLK); #1;
            check_idle_state("reset_abort");
        end
        xfer_chk(1'b0, 0, 8'h00, "reset_abort_read");
    endtask

    task automatic test_psel_drop();
        sel = 1'b1;
        xfer_chk(1'b1, 2, 8'h5A, "drop_pre");
        psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 4'd2; pwdata = 8'h77;
        @(negedge PCLK); #1;
        penable = 1'b1;
        @(negedge PCLK); #1;
        psel = 1'b0; penable = 1'b0;
        repeat (5) begin
            @(negedge PCLK); #1;
            check_idle_state("psel_drop");
        end
        xfer_chk(1'b0, 2, 8'h00, "drop_read");
    endtask

    task automatic test_penable_only();
        sel = 1'b0;
        @(negedge PCLK); #1;
        psel = 1'b1; penable = 1'b1; pwrite = 1'b1; paddr = 4'd1; pwdata = 8'hEE;
        repeat (3) begin
            @(negedge PCLK); #1;
            check_idle_state("penable_only");
        end
        psel = 1'b0; penable = 1'b0;
        @(negedge PCLK); #1;
        xfer_chk(1'b0, 1, 8'h00, "penable_only_read");
    endtask

    task automatic test_back_to_back();
        for (int d = 0; d < 2; d++) begin
            sel = d[0];
            xfer_chk(1'b1, 0, 8'hC3 ^ 8'(d), "b2b_w0");
            xfer_chk(1'b1, 1, 8'h3C ^ 8'(d), "b2b_w1");
            xfer_chk(1'b0, 0, 8'h00, "b2b_r0");
            xfer_chk(1'b0, 1, 8'h00, "b2b_r1");
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 60; n++) begin
            sel = 1'($urandom_range(0, 1));
            xfer_chk(1'($urandom_range(0, 1)), int'($urandom_range(0, 6)),
                     8'($urandom), "random");
        end
    endtask

    initial begin
        PRESET = 1'b0; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
        paddr = '0; pwdata = '0; sel = 1'b0;
        reg_in = {8'h3C, 24'($urandom)};
        clear_model();
        test_reset();
        test_zero_wait();
        test_wait_states();
        test_read_only();
        test_reset_abort();
        test_psel_drop();
        test_penable_only();
        test_back_to_back();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
